// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: arbitrates exceptions, interrupts and mret,
// then holds a registered fetch redirect until the frontend acknowledges it.
module trap_ctrl #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int CODE = 5,
  parameter int NIRQ = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [ADDR-1:0] commit_pc,
  input  logic            commit_exp,
  input  logic [CODE-1:0] commit_code,
  input  logic [DATA-1:0] commit_tval,
  input  logic            commit_mret,
  input  logic [NIRQ-1:0] irq_pend,
  input  logic [NIRQ-1:0] irq_en,
  input  logic            creg_gie,
  input  logic [DATA-1:0] creg_tvec,
  input  logic [DATA-1:0] creg_epc,
  input  logic            flush_ack,
  output logic            flush_req,
  output logic [ADDR-1:0] flush_pc,
  output logic            commit_stall,
  output logic            commit_kill,
  output logic            csr_trap_we,
  output logic            csr_ret_we,
  output logic [DATA-1:0] csr_epc,
  output logic [DATA-1:0] csr_cause,
  output logic [DATA-1:0] csr_tval
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [NIRQ-1:0] act;
  logic [CODE-1:0] irq_idx;
  logic            irq_ok;
  logic            take_exp, take_irq, take_mret, take_trap;
  logic [ADDR-1:0] base;
  logic [ADDR-1:0] target_nxt;
  logic [DATA-1:0] cause_nxt;
  logic [DATA-1:0] tval_nxt;

  always_comb begin
    act     = irq_pend & irq_en;
    irq_idx = '0;
    // ascending scan so the highest set line is the one left standing
    for (int i = 0; i < NIRQ; i++) begin
      if (act[i]) irq_idx = CODE'(i);
    end
    irq_ok = creg_gie && (act != '0);
    base   = ADDR'({creg_tvec[DATA-1:2], 2'b00});

    take_exp  = (state == IDLE) && commit_valid && commit_exp;
    take_irq  = (state == IDLE) && commit_valid && !commit_exp && irq_ok;
    take_mret = (state == IDLE) && commit_valid && !commit_exp && !irq_ok && commit_mret;
    take_trap = take_exp || take_irq;

    target_nxt = base;
    cause_nxt  = '0;
    tval_nxt   = '0;
    if (take_irq) begin
      cause_nxt[DATA-1]   = 1'b1;
      cause_nxt[CODE-1:0] = irq_idx;
      if (creg_tvec[1:0] == 2'b01) target_nxt = base + (ADDR'(irq_idx) << 2);
    end else if (take_exp) begin
      cause_nxt[CODE-1:0] = commit_code;
      tval_nxt            = commit_tval;
    end
    if (take_mret) target_nxt = ADDR'(creg_epc) & ~ADDR'(1);

    commit_kill = !reset && (take_trap || take_mret);

    state_nxt = state;
    case (state)
      IDLE:    if (take_trap || take_mret) state_nxt = FLUSH;
      FLUSH:   if (flush_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // redirect target and CSR data only change when an event is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pc    <= '0;
      csr_trap_we <= 1'b0;
      csr_ret_we  <= 1'b0;
      csr_epc     <= '0;
      csr_cause   <= '0;
      csr_tval    <= '0;
    end else begin
      csr_trap_we <= take_trap;
      csr_ret_we  <= take_mret;
      if (take_trap || take_mret) flush_pc <= target_nxt;
      if (take_trap) begin
        csr_epc   <= DATA'(commit_pc);
        csr_cause <= cause_nxt;
        csr_tval  <= tval_nxt;
      end
    end
  end

  assign flush_req    = (state == FLUSH);
  assign commit_stall = (state != IDLE);

endmodule
